// File: rtl/scarv_cop_dispatch.sv
// scarv_cop_dispatch: instruction sequencer between the CPU-coprocessor interface and the
// decoder / functional-unit array. Only one instruction is in flight. The FSM steps through
// accept, decode, an optional register-file init or unit execution under a watchdog, and a
// held GPR writeback response.
module scarv_cop_dispatch #(
    parameter int unsigned NCLASS  = 9,   // width of the one-hot class vector
    parameter int unsigned TIMEOUT = 64,  // max EXEC cycles before abort (>= 2)
    parameter int unsigned TW      = 7    // watchdog width, 2^TW > TIMEOUT
) (
    input  logic              g_clk,
    input  logic              g_resetn,

    // CPU request channel
    input  logic              cpu_insn_req,
    output logic              cop_insn_ack,
    input  logic [31:0]       cpu_insn_enc,

    // CPU response channel
    output logic              cop_insn_rsp,
    input  logic              cpu_insn_ack,
    output logic [4:0]        cop_insn_rd,
    output logic              cop_wen,
    output logic [31:0]       cop_result,
    output logic [1:0]        cop_status,

    // Combinational decoder
    output logic [31:0]       dec_encoded,
    input  logic              dec_exception,
    input  logic [NCLASS-1:0] dec_class,
    input  logic              dec_cprs_init,
    input  logic [4:0]        dec_rd,

    // Functional units
    output logic              cprs_init,
    output logic [NCLASS-1:0] fu_ivalid,
    input  logic [NCLASS-1:0] fu_idone,
    input  logic              fu_gpr_wen,
    input  logic [31:0]       fu_gpr_wdata,
    output logic              fu_flush,

    output logic [31:0]       insn_count
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StInit,
        StExec,
        StResp
    } state_t;

    localparam logic [TW-1:0] WdogLast = TW'(TIMEOUT - 1);

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusIllegal = 2'd1;
    localparam logic [1:0] StatusTimeout = 2'd2;

    state_t            r_state;
    logic [31:0]       r_insn;
    logic [NCLASS-1:0] r_class;
    logic [4:0]        r_rd;
    logic [TW-1:0]     r_wdog;
    logic [1:0]        r_status;
    logic              r_wen;
    logic [31:0]       r_result;
    logic [31:0]       r_count;

    // Registered interface outputs, all Moore
    logic              r_ack;
    logic              r_rsp;
    logic              r_cprs_init;
    logic [NCLASS-1:0] r_ivalid;

    logic              w_exec;
    logic              w_done;
    logic              w_expire;
    logic              w_illegal;

    // Completion only counts on the selected class; stray done bits from other units are ignored.
    assign w_exec    = (r_state == StExec);
    assign w_done    = w_exec && (|(fu_idone & r_class));
    // Completion in the last watchdog cycle wins over the abort.
    assign w_expire  = w_exec && !w_done && (r_wdog == WdogLast);
    assign w_illegal = dec_exception || ((dec_class == '0) && !dec_cprs_init);

    // Sequencer: state, captured instruction context and registered outputs
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state     <= StIdle;
            r_insn      <= '0;
            r_class     <= '0;
            r_rd        <= '0;
            r_wdog      <= '0;
            r_status    <= StatusOk;
            r_wen       <= 1'b0;
            r_result    <= '0;
            r_count     <= '0;
            r_ack       <= 1'b1;
            r_rsp       <= 1'b0;
            r_cprs_init <= 1'b0;
            r_ivalid    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (cpu_insn_req) begin
                        r_insn  <= cpu_insn_enc;
                        r_ack   <= 1'b0;
                        r_state <= StDecode;
                    end
                end

                StDecode: begin
                    r_rd <= dec_rd;
                    // Exception is checked first so it overrides an init flag.
                    if (w_illegal) begin
                        r_status <= StatusIllegal;
                        r_wen    <= 1'b0;
                        r_result <= '0;
                        r_rsp    <= 1'b1;
                        r_state  <= StResp;
                    end else if (dec_cprs_init) begin
                        r_cprs_init <= 1'b1;
                        r_state     <= StInit;
                    end else begin
                        r_class  <= dec_class;
                        r_ivalid <= dec_class;
                        r_wdog   <= '0;
                        r_state  <= StExec;
                    end
                end

                StInit: begin
                    r_cprs_init <= 1'b0;
                    r_status    <= StatusOk;
                    r_wen       <= 1'b0;
                    r_result    <= '0;
                    r_rsp       <= 1'b1;
                    r_state     <= StResp;
                end

                StExec: begin
                    if (w_done) begin
                        r_wen    <= fu_gpr_wen;
                        r_result <= fu_gpr_wen ? fu_gpr_wdata : 32'd0;
                        r_status <= StatusOk;
                        r_ivalid <= '0;
                        r_rsp    <= 1'b1;
                        r_state  <= StResp;
                    end else if (w_expire) begin
                        r_wen    <= 1'b0;
                        r_result <= '0;
                        r_status <= StatusTimeout;
                        r_ivalid <= '0;
                        r_rsp    <= 1'b1;
                        r_state  <= StResp;
                    end else begin
                        r_wdog <= r_wdog + TW'(1);
                    end
                end

                StResp: begin
                    if (cpu_insn_ack) begin
                        r_count <= r_count + 32'd1;
                        r_rsp   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_state     <= StIdle;
                    r_ack       <= 1'b1;
                    r_rsp       <= 1'b0;
                    r_cprs_init <= 1'b0;
                    r_ivalid    <= '0;
                end
            endcase
        end
    end

    // Response fields read as zero whenever no response is being presented.
    assign cop_insn_ack = r_ack;
    assign cop_insn_rsp = r_rsp;
    assign cop_insn_rd  = r_rsp ? r_rd : 5'd0;
    assign cop_wen      = r_rsp & r_wen;
    assign cop_result   = r_rsp ? r_result : 32'd0;
    assign cop_status   = r_rsp ? r_status : 2'd0;

    assign dec_encoded  = r_insn;
    assign cprs_init    = r_cprs_init;
    assign fu_ivalid    = r_ivalid;
    assign fu_flush     = w_expire;
    assign insn_count   = r_count;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Self-checking bench for scarv_cop_dispatch. The bench plays CPU, decoder and functional
// units, and keeps a transaction-level model: per instruction it tracks only "cycles since
// accept" and derives every expected output from the instruction kind and planned latency.
module tb_scarv_cop_dispatch;

    localparam int NCLASS  = 9;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    localparam int KFu   = 0;
    localparam int KIll  = 1;
    localparam int KInit = 2;

    logic              g_clk;
    logic              g_resetn;
    logic              cpu_insn_req;
    logic              cop_insn_ack;
    logic [31:0]       cpu_insn_enc;
    logic              cop_insn_rsp;
    logic              cpu_insn_ack;
    logic [4:0]        cop_insn_rd;
    logic              cop_wen;
    logic [31:0]       cop_result;
    logic [1:0]        cop_status;
    logic [31:0]       dec_encoded;
    logic              dec_exception;
    logic [NCLASS-1:0] dec_class;
    logic              dec_cprs_init;
    logic [4:0]        dec_rd;
    logic              cprs_init;
    logic [NCLASS-1:0] fu_ivalid;
    logic [NCLASS-1:0] fu_idone;
    logic              fu_gpr_wen;
    logic [31:0]       fu_gpr_wdata;
    logic              fu_flush;
    logic [31:0]       insn_count;

    scarv_cop_dispatch #(
        .NCLASS  (NCLASS),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .cpu_insn_req  (cpu_insn_req),
        .cop_insn_ack  (cop_insn_ack),
        .cpu_insn_enc  (cpu_insn_enc),
        .cop_insn_rsp  (cop_insn_rsp),
        .cpu_insn_ack  (cpu_insn_ack),
        .cop_insn_rd   (cop_insn_rd),
        .cop_wen       (cop_wen),
        .cop_result    (cop_result),
        .cop_status    (cop_status),
        .dec_encoded   (dec_encoded),
        .dec_exception (dec_exception),
        .dec_class     (dec_class),
        .dec_cprs_init (dec_cprs_init),
        .dec_rd        (dec_rd),
        .cprs_init     (cprs_init),
        .fu_ivalid     (fu_ivalid),
        .fu_idone      (fu_idone),
        .fu_gpr_wen    (fu_gpr_wen),
        .fu_gpr_wdata  (fu_gpr_wdata),
        .fu_flush      (fu_flush),
        .insn_count    (insn_count)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    // ---------------- Bench decoder ----------------
    // enc[31:29] selects the kind, enc[15:12] the class index, enc[11:7] rd.
    typedef struct packed {
        logic              exc;
        logic [NCLASS-1:0] cls;
        logic              init;
        logic [4:0]        rd;
    } dec_t;

    function automatic dec_t dec_fn(input logic [31:0] e);
        dec_t d;
        logic [NCLASS-1:0] oh;
        int idx;
        idx = int'(e[15:12]) % NCLASS;
        oh = '0;
        oh[idx] = 1'b1;
        d.rd = e[11:7];
        d.exc = 1'b0;
        d.init = 1'b0;
        d.cls = oh;
        case (e[31:29])
            3'd4: begin d.exc = 1'b1; d.init = e[27]; d.cls = e[28] ? oh : '0; end
            3'd5: begin d.init = 1'b1; d.cls = e[28] ? oh : '0; end
            3'd6: begin d.cls = '0; end
            default: ;
        endcase
        return d;
    endfunction

    dec_t w_dec;
    dec_t w_cpu_dec;
    assign w_dec         = dec_fn(dec_encoded);
    assign dec_exception = w_dec.exc;
    assign dec_class     = w_dec.cls;
    assign dec_cprs_init = w_dec.init;
    assign dec_rd        = w_dec.rd;
    assign w_cpu_dec     = dec_fn(cpu_insn_enc);

    function automatic logic [31:0] mk_enc(input int sel, input int cls, input int rd);
        logic [31:0] e;
        e = $urandom;
        e[31:29] = 3'(sel);
        e[15:12] = 4'(cls);
        e[11:7]  = 5'(rd);
        return e;
    endfunction

    // ---------------- Transaction-level model ----------------
    function automatic int kind_of(input dec_t d);
        if (d.exc || (d.cls == '0 && !d.init)) return KIll;
        if (d.init) return KInit;
        return KFu;
    endfunction

    // Edges from the accept edge (counted as 1) to the edge that raises the response.
    function automatic int lat_of(input int kind, input int n);
        if (kind == KIll) return 2;
        if (kind == KInit) return 3;
        return (n < TIMEOUT) ? 3 + n : 3 + TIMEOUT - 1;
    endfunction

    // Plan for the next accepted instruction: done after n EXEC cycles, response ack delay d.
    int          cand_n, cand_d;
    logic        cand_wen;
    logic [31:0] cand_wdata;

    logic              m_busy;
    int                m_j, m_L, m_kind, m_n, m_d;
    logic [NCLASS-1:0] m_cls;
    logic [4:0]        m_rd;
    logic              m_wen;
    logic [31:0]       m_wdata;
    logic [31:0]       m_insn;
    logic [31:0]       m_count;

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            m_busy  <= 1'b0;
            m_j     <= 0;
            m_count <= '0;
            m_insn  <= '0;
        end else if (!m_busy) begin
            if (cpu_insn_req) begin
                m_busy  <= 1'b1;
                m_j     <= 1;
                m_insn  <= cpu_insn_enc;
                m_kind  <= kind_of(w_cpu_dec);
                m_L     <= lat_of(kind_of(w_cpu_dec), cand_n);
                m_cls   <= w_cpu_dec.cls;
                m_rd    <= w_cpu_dec.rd;
                m_n     <= cand_n;
                m_d     <= cand_d;
                m_wen   <= cand_wen;
                m_wdata <= cand_wdata;
            end
        end else if (m_j >= m_L && cpu_insn_ack) begin
            m_busy  <= 1'b0;
            m_count <= m_count + 32'd1;
        end else begin
            m_j <= m_j + 1;
        end
    end

    // ---------------- Checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_exec();
        return m_busy && m_kind == KFu && m_j >= 2 && m_j < m_L;
    endfunction

    // Every-cycle compare of all DUT outputs against the model.
    task automatic check_cycle();
        logic        rsp;
        logic        to;
        logic [1:0]  st;
        logic        wen;
        rsp = m_busy && m_j >= m_L;
        to  = (m_kind == KFu) && (m_n >= TIMEOUT);
        st  = (m_kind == KIll) ? 2'd1 : (to ? 2'd2 : 2'd0);
        wen = (m_kind == KFu) && !to && m_wen;
        chk("ack", 32'(cop_insn_ack), 32'(!m_busy));
        chk("rsp", 32'(cop_insn_rsp), 32'(rsp));
        chk("rd", 32'(cop_insn_rd), rsp ? 32'(m_rd) : 32'd0);
        chk("wen", 32'(cop_wen), rsp ? 32'(wen) : 32'd0);
        chk("status", 32'(cop_status), rsp ? 32'(st) : 32'd0);
        if (!rsp) chk("result_idle", cop_result, 32'd0);
        else if (m_kind == KFu) chk("result", cop_result, wen ? m_wdata : 32'd0);
        chk("ivalid", 32'(fu_ivalid), in_exec() ? 32'(m_cls) : 32'd0);
        chk("cprs_init", 32'(cprs_init), 32'(m_busy && m_kind == KInit && m_j == 2));
        chk("flush", 32'(fu_flush), 32'(in_exec() && to && m_j == m_L - 1));
        chk("count", insn_count, m_count);
        chk("dec_enc", dec_encoded, m_insn);
    endtask

    // One cycle: drive FU/CPU responses from the model's view, then compare.
    task automatic tick();
        logic [NCLASS-1:0] junk;
        logic done_now;
        @(negedge g_clk);
        done_now = in_exec() && (m_j - 2 == m_n);
        junk = NCLASS'($urandom);
        if (in_exec()) junk = junk & ~m_cls;
        fu_idone     = junk | (done_now ? m_cls : '0);
        fu_gpr_wen   = done_now ? m_wen : 1'($urandom);
        fu_gpr_wdata = done_now ? m_wdata : $urandom;
        if (m_busy && m_j >= m_L) cpu_insn_ack = (m_j >= m_L + m_d);
        else cpu_insn_ack = 1'($urandom);
        #1;
        check_cycle();
    endtask

    // Issue one instruction from idle and run it to the response handshake.
    task automatic run_op(input logic [31:0] enc, input int n, input logic wen,
                          input logic [31:0] wdata, input int d,
                          output int lat, output int ivc, output int flc, output int cpc,
                          output logic [1:0] st, output logic [31:0] res,
                          output logic [NCLASS-1:0] iv_or);
        int k;
        cand_n = n; cand_wen = wen; cand_wdata = wdata; cand_d = d;
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        lat = 0; ivc = 0; flc = 0; cpc = 0; st = 2'd3; res = 32'hx; iv_or = '0;
        tick();
        chk("accept", 32'(m_busy), 32'd1);
        k = 1;
        while (m_busy && k < 300) begin
            // Requests while busy must be ignored.
            cpu_insn_req = 1'($urandom);
            cpu_insn_enc = $urandom;
            tick();
            k++;
            if (fu_ivalid != '0) ivc++;
            iv_or = iv_or | fu_ivalid;
            if (fu_flush) flc++;
            if (cprs_init) cpc++;
            if (cop_insn_rsp && lat == 0) begin
                lat = k;
                st = cop_status;
                res = cop_result;
            end
        end
        cpu_insn_req = 1'b0;
        if (m_busy) chk("op_bound", 32'(k), 32'd0);
    endtask

    int lat, ivc, flc, cpc;
    logic [1:0] st;
    logic [31:0] res;
    logic [NCLASS-1:0] ivor;

    initial begin
        g_resetn = 1'b0;
        cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_insn_ack = 1'b0;
        fu_idone = '0; fu_gpr_wen = 1'b0; fu_gpr_wdata = '0;
        cand_n = 0; cand_d = 0; cand_wen = 1'b0; cand_wdata = '0;
        repeat (3) tick();
        chk("reset_ack", 32'(cop_insn_ack), 32'd1);
        g_resetn = 1'b1;
        tick();

        // Class bit 2, done in the first EXEC cycle.
        run_op(mk_enc(0, 2, 17), 0, 1'b1, 32'hDEADBEEF, 0, lat, ivc, flc, cpc, st, res, ivor);
        chk("d1_lat", 32'(lat), 32'd3);
        chk("d1_result", res, 32'hDEADBEEF);
        chk("d1_status", 32'(st), 32'd0);
        chk("d1_ivalid", 32'(ivor), 32'h004);
        chk("d1_count", insn_count, 32'd1);

        // Exception, also carrying an init flag and a class: exception wins.
        run_op(mk_enc(4, 1, 3) | 32'h1800_0000, 0, 1'b1, 32'h1, 0,
               lat, ivc, flc, cpc, st, res, ivor);
        chk("d2_lat", 32'(lat), 32'd2);
        chk("d2_status", 32'(st), 32'd1);
        chk("d2_ivc", 32'(ivc), 32'd0);
        chk("d2_cpc", 32'(cpc), 32'd0);

        // Init.
        run_op(mk_enc(5, 0, 9), 0, 1'b1, 32'h1, 0, lat, ivc, flc, cpc, st, res, ivor);
        chk("d3_lat", 32'(lat), 32'd3);
        chk("d3_cpc", 32'(cpc), 32'd1);
        chk("d3_status", 32'(st), 32'd0);

        // Never completes: watchdog abort.
        run_op(mk_enc(1, 7, 4), 1000, 1'b1, 32'h55, 0, lat, ivc, flc, cpc, st, res, ivor);
        chk("d4_ivc", 32'(ivc), 32'd64);
        chk("d4_flush", 32'(flc), 32'd1);
        chk("d4_status", 32'(st), 32'd2);
        chk("d4_result", res, 32'd0);

        // Done in the 64th EXEC cycle wins over the abort.
        run_op(mk_enc(2, 0, 8), 63, 1'b1, 32'h1234, 0, lat, ivc, flc, cpc, st, res, ivor);
        chk("d5_ivc", 32'(ivc), 32'd64);
        chk("d5_flush", 32'(flc), 32'd0);
        chk("d5_status", 32'(st), 32'd0);
        chk("d5_result", res, 32'h1234);

        // CPU stalls the response 5 cycles.
        run_op(mk_enc(3, 5, 30), 2, 1'b0, 32'hFFFF, 5, lat, ivc, flc, cpc, st, res, ivor);
        chk("d6_lat", 32'(lat), 32'd5);
        chk("d6_count", insn_count, 32'd6);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int r, n;
            r = $urandom_range(0, 9);
            n = (r <= 6) ? r : ((r == 7) ? 62 : ((r == 8) ? 63 : 1000));
            run_op(mk_enc($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 31)),
                   n, 1'($urandom), $urandom, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5),
                   lat, ivc, flc, cpc, st, res, ivor);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the middle of EXEC drops the instruction.
        cand_n = 1000; cand_d = 0;
        cpu_insn_req = 1'b1;
        cpu_insn_enc = mk_enc(0, 4, 12);
        tick();
        cpu_insn_req = 1'b0;
        repeat (10) tick();
        chk("pre_rst_exec", 32'(fu_ivalid), 32'h010);
        g_resetn = 1'b0;
        #1;
        check_cycle();
        chk("rst_count", insn_count, 32'd0);
        chk("rst_ack", 32'(cop_insn_ack), 32'd1);
        repeat (2) tick();
        g_resetn = 1'b1;
        tick();
        run_op(mk_enc(0, 6, 21), 3, 1'b1, 32'hCAFE0001, 1, lat, ivc, flc, cpc, st, res, ivor);
        chk("post_rst_lat", 32'(lat), 32'd6);
        chk("post_rst_result", res, 32'hCAFE0001);
        chk("post_rst_count", insn_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_dispatch.md
Name: scarv_cop_dispatch

Overview:
Sequencing controller for the coprocessor ISE. It accepts one instruction at a time from the host CPU and registers it into the combinational instruction decoder. It then dispatches the instruction to the functional unit selected by the one-hot class vector, waits for completion under a watchdog, and returns a GPR writeback response with status. It sits between the CPU-coprocessor interface and the decoder/functional-unit array.

Parameters:
NCLASS, 9, width of one-hot class vector (matches decoder id_class).
TIMEOUT, 64, max EXEC cycles before abort (≥2).
TW, 7, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
g_clk  in  1  clock, all state on rising edge.
g_resetn  in  1  asynchronous active-low reset.
cpu_insn_req  in  1  CPU presents an instruction.
cop_insn_ack  out  1  coprocessor accepts; transfer when req&&ack.
cpu_insn_enc  in  32  encoded instruction.
cop_insn_rsp  out  1  response valid.
cpu_insn_ack  in  1  CPU accepts response; transfer when rsp&&ack.
cop_insn_rd  out  5  GPR destination.
cop_wen  out  1  write cop_result to cop_insn_rd.
cop_result  out  32  GPR writeback data.
cop_status  out  2  0 ok, 1 illegal, 2 timeout, 3 reserved (never driven).
dec_encoded  out  32  to decoder input.
dec_exception  in  1  decoder illegal-instruction flag.
dec_class  in  NCLASS  decoder one-hot class.
dec_cprs_init  in  1  decoder init-instruction flag.
dec_rd  in  5  decoder GPR rd.
cprs_init  out  1  one-cycle pulse: clear coprocessor register file.
fu_ivalid  out  NCLASS  per-class issue valid.
fu_idone  in  NCLASS  per-class completion.
fu_gpr_wen  in  1  completing unit writes a GPR.
fu_gpr_wdata  in  32  completing unit GPR data.
fu_flush  out  1  one-cycle abort pulse to all units.
insn_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async, g_resetn=0): state IDLE. All outputs 0 except cop_insn_ack=1. insn_q, class_q, rd_q, counters cleared. Reset mid-instruction drops it silently; no response is issued.
- FSM states: IDLE, DECODE, INIT, EXEC, RESP.
- IDLE: cop_insn_ack=1 (Moore, state only). On req&&ack: insn_q<=cpu_insn_enc; go DECODE. No accept in any other state.
- dec_encoded=insn_q at all times (registered drive; decoder is combinational).
- DECODE, one cycle: rd_q<=dec_rd.
  - dec_exception=1, or (dec_class==0 && !dec_cprs_init): status_q<=1, wen_q<=0; go RESP.
  - dec_cprs_init=1 (and no exception): go INIT.
  - Otherwise: class_q<=dec_class, wdog<=0; go EXEC.
  - dec_exception takes priority over init.
- INIT: cprs_init=1 for exactly this cycle; status_q<=0, wen_q<=0; go RESP.
- EXEC:
  - fu_ivalid=class_q, held stable every EXEC cycle.
  - Completion = |(fu_idone & class_q). fu_idone bits outside class_q are ignored.
  - On completion: wen_q<=fu_gpr_wen; result_q<=fu_gpr_wen ? fu_gpr_wdata : 0; status_q<=0; go RESP. Completion in the first EXEC cycle is legal.
  - Else wdog increments. When wdog==TIMEOUT-1 without completion: fu_flush=1 that cycle, status_q<=2, wen_q<=0, result_q<=0; go RESP. Completion in the same cycle wins over timeout (no flush).
- RESP:
  - cop_insn_rsp=1; cop_insn_rd=rd_q, cop_wen=wen_q, cop_result=result_q, cop_status=status_q, all held stable until cpu_insn_ack.
  - On rsp&&ack: insn_count+=1 (wraps at 2^32, counts all statuses); go IDLE.
  - cop_insn_rd/cop_result/cop_wen/cop_status are driven 0 outside RESP.
- Latency from accept edge to rsp: illegal 2 cycles; init 3; FU op 3+N, where N = EXEC cycles before done (N=0 if done in the first EXEC cycle). Back-to-back: the next accept occurs the cycle after the response handshake, so cop_insn_ack is high the cycle after rsp&&ack.
- Only one instruction is in flight at any time. cpu_insn_enc is sampled only on the accept edge.

Test Plan:
- Reset then req with a valid instruction; decoder returns class bit 2, FU asserts done in the first EXEC cycle with wen=1, wdata=0xDEADBEEF -> rsp at cycle 3, wen=1, result=0xDEADBEEF, status=0, rd=dec_rd, insn_count=1.
- Decoder asserts dec_exception=1 -> rsp at cycle 2, status=1, wen=0, fu_ivalid never asserted.
- dec_cprs_init=1 -> cprs_init high for exactly 1 cycle, rsp status=0, wen=0.
- FU never completes (TIMEOUT=64) -> fu_ivalid held 64 cycles, fu_flush pulses once, rsp status=2, result=0; done on cycle 64 instead -> status=0, no flush.
- CPU holds cpu_insn_ack=0 for 5 cycles in RESP -> outputs stable, cop_insn_ack=0, no new accept. Spurious fu_idone on a non-selected class bit -> ignored.
- Deassert g_resetn mid-EXEC -> immediately IDLE, all outputs 0, cop_insn_ack=1, insn_count=0; next instruction completes normally.
